// File: rtl/sd_spi_cmd_engine_if.sv
// Command/response handshake between the card-init sequencer and the
// SD SPI command engine.
interface sd_spi_cmd_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_init;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_long;
    logic        fast_mode;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;

    modport master (
        output cmd_valid, cmd_init, cmd_index, cmd_arg, resp_long, fast_mode,
        input  cmd_ready, resp_valid, resp_r1, resp_data, resp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_init, cmd_index, cmd_arg, resp_long, fast_mode,
        output cmd_ready, resp_valid, resp_r1, resp_data, resp_timeout
    );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command engine: frames a command with CRC7, drives a
// mode-0 SPI bus, polls R1 with a byte timeout and collects an R3/R7 tail.
module sd_spi_cmd_engine #(
    parameter int CLK_HZ             = 100000000,
    parameter int INIT_SCLK_HZ       = 400000,
    parameter int FAST_SCLK_HZ       = 25000000,
    parameter int RESP_TIMEOUT_BYTES = 8,
    parameter int DUMMY_CLOCKS       = 80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sd_spi_cmd_engine_if.slave   bus,
    output logic                 sd_sclk,
    output logic                 sd_mosi,
    input  logic                 sd_miso,
    output logic                 sd_cs_n
);
    localparam int HI_RAW = CLK_HZ / (2 * INIT_SCLK_HZ);
    localparam int HF_RAW = CLK_HZ / (2 * FAST_SCLK_HZ);
    localparam int HALF_INIT = (HI_RAW < 1) ? 1 : HI_RAW;
    localparam int HALF_FAST = (HF_RAW < 1) ? 1 : HF_RAW;
    localparam logic [15:0] HI_M1 = 16'(HALF_INIT - 1);
    localparam logic [15:0] HF_M1 = 16'(HALF_FAST - 1);
    localparam logic [15:0] DUMMY_LAST = 16'(DUMMY_CLOCKS - 1);
    localparam logic [7:0]  TMO_LAST = 8'(RESP_TIMEOUT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DUMMY, S_PRE, S_SEND, S_WAIT, S_RECV, S_POST, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d, bit_q, bit_d;
    logic [7:0]  byte_q, byte_d, r1_q, r1_d, resp_r1_q, resp_r1_d;
    logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic        fast_q, fast_d, long_q, long_d, init_q, init_d;
    logic        hit_q, hit_d, tmo_q, tmo_d, resp_tmo_q, resp_tmo_d;
    logic [47:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d, resp_data_q, resp_data_d;
    logic [15:0] half_m1;
    logic        active, tick, rise, fall;
    logic [39:0] hdr;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign hdr = {2'b01, bus.cmd_index, bus.cmd_arg};

    // State register and all datapath flops; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;     div_q <= '0;       bit_q <= '0;
            byte_q <= '0;          r1_q <= 8'hFF;     sclk_q <= 1'b0;
            mosi_q <= 1'b1;        cs_n_q <= 1'b1;    fast_q <= 1'b0;
            long_q <= 1'b0;        init_q <= 1'b0;    hit_q <= 1'b0;
            tmo_q <= 1'b0;         tx_q <= '0;        rx_q <= '0;
            resp_r1_q <= 8'hFF;    resp_data_q <= '0; resp_tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;    div_q <= div_d;    bit_q <= bit_d;
            byte_q <= byte_d;      r1_q <= r1_d;      sclk_q <= sclk_d;
            mosi_q <= mosi_d;      cs_n_q <= cs_n_d;  fast_q <= fast_d;
            long_q <= long_d;      init_q <= init_d;  hit_q <= hit_d;
            tmo_q <= tmo_d;        tx_q <= tx_d;      rx_q <= rx_d;
            resp_r1_q <= resp_r1_d;
            resp_data_q <= resp_data_d;
            resp_tmo_q <= resp_tmo_d;
        end
    end

    // SCLK divider, next-state and bit/byte sequencing.
    always_comb begin
        state_d = state_q;  div_d = div_q;    bit_d = bit_q;
        byte_d = byte_q;    r1_d = r1_q;      sclk_d = sclk_q;
        mosi_d = mosi_q;    cs_n_d = cs_n_q;  fast_d = fast_q;
        long_d = long_q;    init_d = init_q;  hit_d = hit_q;
        tmo_d = tmo_q;      tx_d = tx_q;      rx_d = rx_q;
        resp_r1_d = resp_r1_q;
        resp_data_d = resp_data_q;
        resp_tmo_d = resp_tmo_q;
        half_m1 = fast_q ? HF_M1 : HI_M1;
        active = (state_q != S_IDLE) && (state_q != S_DONE);
        tick = active && (div_q == half_m1);
        rise = tick && !sclk_q;
        fall = tick && sclk_q;
        if (active) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
            if (tick) sclk_d = !sclk_q;
        end
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                init_d = bus.cmd_init;
                long_d = bus.resp_long;
                fast_d = bus.fast_mode;
                tx_d = {hdr, crc7(hdr), 1'b1};
                div_d = '0;  bit_d = '0;  byte_d = '0;
                mosi_d = 1'b1;  tmo_d = 1'b0;  hit_d = 1'b0;
                r1_d = 8'hFF;  rx_d = '0;
                cs_n_d = bus.cmd_init;
                state_d = bus.cmd_init ? S_DUMMY : S_PRE;
            end
            S_DUMMY: if (fall) begin
                bit_d = bit_q + 16'd1;
                if (bit_q == DUMMY_LAST) state_d = S_DONE;
            end
            S_PRE: if (fall) begin
                bit_d = bit_q + 16'd1;
                if (bit_q == 16'd7) begin
                    bit_d = '0;
                    mosi_d = tx_q[47];
                    tx_d = tx_q << 1;
                    state_d = S_SEND;
                end
            end
            S_SEND: if (fall) begin
                bit_d = bit_q + 16'd1;
                mosi_d = tx_q[47];
                tx_d = tx_q << 1;
                if (bit_q == 16'd47) begin
                    bit_d = '0;
                    mosi_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rise) begin
                    r1_d = {r1_q[6:0], sd_miso};
                    if (bit_q == 16'd0 && !sd_miso) hit_d = 1'b1;
                end
                if (fall) begin
                    bit_d = bit_q + 16'd1;
                    if (bit_q == 16'd7) begin
                        bit_d = '0;
                        byte_d = byte_q + 8'd1;
                        if (hit_q) begin
                            state_d = long_q ? S_RECV : S_POST;
                        end else if (byte_q == TMO_LAST) begin
                            tmo_d = 1'b1;
                            state_d = S_POST;
                        end
                    end
                end
            end
            S_RECV: begin
                if (rise) rx_d = {rx_q[30:0], sd_miso};
                if (fall) begin
                    bit_d = bit_q + 16'd1;
                    if (bit_q == 16'd31) begin
                        bit_d = '0;
                        state_d = S_POST;
                    end
                end
            end
            S_POST: if (fall) begin
                bit_d = bit_q + 16'd1;
                if (bit_q == 16'd7) begin
                    cs_n_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE && state_q != S_DONE) begin
            resp_r1_d = (init_q || tmo_q) ? 8'hFF : r1_q;
            resp_data_d = (long_q && !init_q) ? rx_q : 32'd0;
            resp_tmo_d = tmo_q && !init_q;
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.resp_valid   = (state_q == S_DONE);
    assign bus.resp_r1      = resp_r1_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_timeout = resp_tmo_q;
    assign sd_sclk = sclk_q;
    assign sd_mosi = mosi_q;
    assign sd_cs_n = cs_n_q;
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: SD card model on the SPI pins plus a
// frame/latency/response reference model derived from the command rules.
module tb_sd_spi_cmd_engine;
    localparam int HI = 125;
    localparam int HF = 2;
    localparam int TMO_BYTES = 8;
    localparam int DUMMY = 80;
    localparam int LIMIT = 40000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sd_sclk, sd_mosi, sd_miso, sd_cs_n;

    sd_spi_cmd_engine_if bus ();

    sd_spi_cmd_engine dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sd_sclk(sd_sclk), .sd_mosi(sd_mosi),
        .sd_miso(sd_miso), .sd_cs_n(sd_cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int ntot = 0;
    int nbad = 0;

    logic [7:0] card_q[$];
    logic       miso_stream[$];
    logic       mosi_log[$];
    int         rise_cyc[$];
    int         rc = 0;
    int         rise_cs_low = 0;

    int          exp_n, exp_lat;
    logic [7:0]  exp_r1;
    logic [31:0] exp_data;
    logic        exp_tmo;
    logic [47:0] exp_frame;

    int          lat, acc_cyc, idle_zero;
    logic        seen, rdy_at1;
    logic [7:0]  got_r1;
    logic [31:0] got_data;
    logic        got_tmo;
    logic [47:0] got_frame;
    bit          cur_init;

    // Card side: log MOSI on SCLK rise, shift the next MISO bit on fall.
    always @(posedge sd_sclk) begin
        mosi_log.push_back(sd_mosi);
        rise_cyc.push_back(cyc);
        if (sd_cs_n === 1'b0) rise_cs_low++;
        rc++;
    end

    always @(negedge sd_sclk)
        sd_miso = (rc < miso_stream.size()) ? miso_stream[rc] : 1'b1;

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic prep();
        while (card_q.size() < 16) card_q.push_back(8'hFF);
        miso_stream.delete();
        for (int i = 0; i < 56; i++) miso_stream.push_back(1'b1);
        foreach (card_q[i])
            for (int b = 7; b >= 0; b--) miso_stream.push_back(card_q[i][b]);
        mosi_log.delete();
        rise_cyc.delete();
        rc = 0;
        rise_cs_low = 0;
        sd_miso = 1'b1;
    endtask

    task automatic model(input bit init, input bit fast, input bit long,
                         input logic [5:0] idx, input logic [31:0] arg);
        int h, k, pos;
        bit found;
        h = fast ? HF : HI;
        exp_frame = {2'b01, idx, arg, ref_crc({2'b01, idx, arg}), 1'b1};
        if (init) begin
            exp_r1 = 8'hFF; exp_data = 0; exp_tmo = 0; exp_n = DUMMY;
        end else begin
            k = 0; pos = 0; found = 0;
            for (int i = 0; i < TMO_BYTES && !found; i++) begin
                k = i + 1;
                if (card_q[i][7] == 1'b0) begin found = 1; pos = i; end
            end
            exp_tmo = !found;
            exp_r1 = found ? card_q[pos] : 8'hFF;
            exp_data = 0;
            if (found && long)
                exp_data = {card_q[pos+1], card_q[pos+2],
                            card_q[pos+3], card_q[pos+4]};
            exp_n = 8 + 48 + 8 * k + 8 + ((found && long) ? 32 : 0);
        end
        exp_lat = exp_n * 2 * h + 1;
    endtask

    task automatic start(input bit init, input bit fast, input bit long,
                         input logic [5:0] idx, input logic [31:0] arg);
        @(negedge clk);
        prep();
        cur_init = init;
        bus.cmd_init = init;
        bus.fast_mode = fast;
        bus.resp_long = long;
        bus.cmd_index = idx;
        bus.cmd_arg = arg;
        bus.cmd_valid = 1'b1;
        model(init, fast, long, idx, arg);
    endtask

    task automatic wait_resp(input int drop_at);
        lat = 0; seen = 0; rdy_at1 = 0;
        while (lat < LIMIT && !seen) begin
            @(negedge clk);
            lat++;
            if (lat == 1) rdy_at1 = bus.cmd_ready;
            if (lat == drop_at) begin
                acc_cyc = cyc;
                bus.cmd_valid = 1'b0;
                bus.cmd_init = 1'($urandom);
                bus.fast_mode = 1'($urandom);
                bus.resp_long = 1'($urandom);
                bus.cmd_index = 6'($urandom);
                bus.cmd_arg = $urandom;
            end
            if (bus.resp_valid === 1'b1) seen = 1;
        end
        got_r1 = bus.resp_r1;
        got_data = bus.resp_data;
        got_tmo = bus.resp_timeout;
        got_frame = '0;
        idle_zero = 0;
        foreach (mosi_log[i]) begin
            if (!cur_init && i >= 8 && i < 56)
                got_frame = {got_frame[46:0], mosi_log[i]};
            else if (mosi_log[i] !== 1'b1)
                idle_zero++;
        end
    endtask

    task automatic test_reset();
        #12;
        ntot++;
        if ({sd_sclk, sd_mosi, sd_cs_n, bus.resp_valid} !== 4'b0110) begin
            nbad++;
            $display("FAIL reset_pins got=%b exp=0110",
                     {sd_sclk, sd_mosi, sd_cs_n, bus.resp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ntot++;
        if (bus.cmd_ready !== 1'b1) begin
            nbad++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready);
        end
        ntot++;
        if ({bus.resp_r1, bus.resp_data, bus.resp_timeout} !== {8'hFF, 33'd0}) begin
            nbad++;
            $display("FAIL reset_resp got=%h/%h/%b exp=ff/0/0",
                     bus.resp_r1, bus.resp_data, bus.resp_timeout);
        end
    endtask

    task automatic test_cmd8_long();
        card_q = {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        start(0, 1, 1, 6'd8, 32'h1AA);
        wait_resp(1);
        ntot++;
        if (lat != exp_lat) begin
            nbad++; $display("FAIL cmd8_latency got=%0d exp=%0d", lat, exp_lat);
        end
        ntot++;
        if (got_frame !== 48'h48_0000_01AA_87) begin
            nbad++; $display("FAIL cmd8_frame got=%h exp=4800000 1aa87", got_frame);
        end
        ntot++;
        if (got_data !== 32'h1AA || got_r1 !== 8'h01 || got_tmo !== 1'b0) begin
            nbad++;
            $display("FAIL cmd8_resp got=%h/%h/%b exp=01/000001aa/0",
                     got_r1, got_data, got_tmo);
        end
        ntot++;
        if ((rise_cyc.size() < 2 ? -1 : rise_cyc[1] - rise_cyc[0]) != 4) begin
            nbad++; $display("FAIL cmd8_sclk_period got=%0d exp=4",
                             rise_cyc.size() < 2 ? -1 : rise_cyc[1] - rise_cyc[0]);
        end
        ntot++;
        if ((rise_cyc.size() < 1 ? -1 : rise_cyc[0] - acc_cyc) != HF) begin
            nbad++; $display("FAIL cmd8_first_rise got=%0d exp=%0d",
                             rise_cyc.size() < 1 ? -1 : rise_cyc[0] - acc_cyc, HF);
        end
    endtask

    task automatic test_init();
        card_q = {};
        start(1, 0, 1, 6'($urandom), $urandom);
        wait_resp(1);
        ntot++;
        if (lat != 20001) begin
            nbad++; $display("FAIL init_latency got=%0d exp=20001", lat);
        end
        ntot++;
        if (mosi_log.size() != DUMMY || rise_cs_low != 0 || idle_zero != 0) begin
            nbad++;
            $display("FAIL init_clocks got=%0d/%0d/%0d exp=80/0/0",
                     mosi_log.size(), rise_cs_low, idle_zero);
        end
        ntot++;
        if ((rise_cyc.size() < 2 ? -1 : rise_cyc[1] - rise_cyc[0]) != 250) begin
            nbad++; $display("FAIL init_period got=%0d exp=250",
                             rise_cyc.size() < 2 ? -1 : rise_cyc[1] - rise_cyc[0]);
        end
        ntot++;
        if ({got_r1, got_data, got_tmo} !== {8'hFF, 33'd0}) begin
            nbad++;
            $display("FAIL init_resp got=%h/%h/%b exp=ff/0/0", got_r1, got_data, got_tmo);
        end
    endtask

    task automatic test_cmd0();
        card_q = {8'hFF, 8'h01};
        start(0, 0, 0, 6'd0, 32'd0);
        wait_resp(1);
        ntot++;
        if (lat != exp_lat) begin
            nbad++; $display("FAIL cmd0_latency got=%0d exp=%0d", lat, exp_lat);
        end
        ntot++;
        if (got_frame !== 48'h40_0000_0000_95) begin
            nbad++; $display("FAIL cmd0_frame got=%h exp=400000000095", got_frame);
        end
        ntot++;
        if (got_r1 !== 8'h01 || got_tmo !== 1'b0) begin
            nbad++; $display("FAIL cmd0_resp got=%h/%b exp=01/0", got_r1, got_tmo);
        end
        @(negedge clk);
        ntot++;
        if (sd_cs_n !== 1'b1 || bus.resp_valid !== 1'b0) begin
            nbad++; $display("FAIL cmd0_after got=%b%b exp=10", sd_cs_n, bus.resp_valid);
        end
    endtask

    task automatic test_timeout();
        card_q = {};
        for (int i = 0; i < 16; i++) card_q.push_back(8'($urandom) | 8'h80);
        start(0, 1, 1, 6'($urandom), $urandom);
        wait_resp(1);
        ntot++;
        if (mosi_log.size() != 8 + 48 + 64 + 8) begin
            nbad++; $display("FAIL tmo_clocks got=%0d exp=128", mosi_log.size());
        end
        ntot++;
        if ({got_tmo, got_r1, got_data} !== {1'b1, 8'hFF, 32'd0}) begin
            nbad++;
            $display("FAIL tmo_resp got=%b/%h/%h exp=1/ff/0", got_tmo, got_r1, got_data);
        end
        ntot++;
        if (lat != exp_lat) begin
            nbad++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, exp_lat);
        end
    endtask

    task automatic test_random();
        int pre;
        for (int t = 0; t < 12; t++) begin
            pre = $urandom_range(0, 9);
            card_q = {};
            for (int i = 0; i < pre; i++) card_q.push_back(8'($urandom) | 8'h80);
            card_q.push_back(8'($urandom) & 8'h7F);
            for (int i = 0; i < 4; i++) card_q.push_back(8'($urandom));
            start(0, 1, 1'($urandom), 6'($urandom), $urandom);
            wait_resp(1);
            ntot++;
            if (lat != exp_lat) begin
                nbad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, lat, exp_lat);
            end
            ntot++;
            if ({got_r1, got_data, got_tmo} !== {exp_r1, exp_data, exp_tmo}) begin
                nbad++;
                $display("FAIL rnd%0d_resp got=%h/%h/%b exp=%h/%h/%b", t,
                         got_r1, got_data, got_tmo, exp_r1, exp_data, exp_tmo);
            end
            ntot++;
            if (got_frame !== exp_frame) begin
                nbad++; $display("FAIL rnd%0d_frame got=%h exp=%h", t, got_frame, exp_frame);
            end
            ntot++;
            if (mosi_log.size() != exp_n || rise_cs_low != exp_n || idle_zero != 0) begin
                nbad++;
                $display("FAIL rnd%0d_clocks got=%0d/%0d/%0d exp=%0d/%0d/0", t,
                         mosi_log.size(), rise_cs_low, idle_zero, exp_n, exp_n);
            end
            @(negedge clk);
            ntot++;
            if (sd_cs_n !== 1'b1 || bus.resp_valid !== 1'b0) begin
                nbad++;
                $display("FAIL rnd%0d_after got=%b%b exp=10", t, sd_cs_n, bus.resp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        card_q = {8'hFF, 8'h01};
        start(0, 1, 0, 6'd55, 32'h0);
        wait_resp(0);
        ntot++;
        if (lat != exp_lat) begin
            nbad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, exp_lat);
        end
        ntot++;
        if (bus.cmd_ready !== 1'b0) begin
            nbad++; $display("FAIL b2b_ready_in_done got=%b exp=0", bus.cmd_ready);
        end
        prep();
        wait_resp(2);
        ntot++;
        if (rdy_at1 !== 1'b1) begin
            nbad++; $display("FAIL b2b_ready_next got=%b exp=1", rdy_at1);
        end
        ntot++;
        if (lat != exp_lat + 1) begin
            nbad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, exp_lat + 1);
        end
        ntot++;
        if (got_frame !== exp_frame || got_r1 !== 8'h01) begin
            nbad++;
            $display("FAIL b2b_second_resp got=%h/%h exp=%h/01", got_frame, got_r1, exp_frame);
        end
    endtask

    task automatic test_reset_mid_send();
        int n, vcnt, cslow;
        card_q = {8'h01};
        start(0, 1, 0, 6'($urandom), $urandom);
        n = 0;
        while (rc < 20 && n < 500) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.cmd_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({sd_sclk, sd_mosi, sd_cs_n, bus.resp_valid} !== 4'b0110 || n >= 500) begin
            nbad++;
            $display("FAIL midrst_pins got=%b n=%0d exp=0110",
                     {sd_sclk, sd_mosi, sd_cs_n, bus.resp_valid}, n);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0; cslow = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) vcnt++;
            if (sd_cs_n !== 1'b1) cslow++;
        end
        ntot++;
        if (vcnt != 0 || cslow != 0) begin
            nbad++; $display("FAIL midrst_quiet got=%0d/%0d exp=0/0", vcnt, cslow);
        end
        ntot++;
        if (bus.cmd_ready !== 1'b1) begin
            nbad++; $display("FAIL midrst_ready got=%b exp=1", bus.cmd_ready);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_init = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg = '0;
        bus.resp_long = 1'b0;
        bus.fast_mode = 1'b0;
        sd_miso = 1'b1;
        test_reset();
        test_cmd8_long();
        test_init();
        test_cmd0();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
